// File: rtl/memory_bank_drain.sv
// Read-side controller for the shared DynVC memory bank: per-VC occupancy and
// credit tracking, round-robin read arbitration and a registered output link.
module memory_bank_drain #(
  parameter int max_vc_number     = 4,
  parameter int memory_bank_depth = 32,
  parameter int memory_bank_width = 64,
  parameter int credit_count      = 4,
  localparam int vc_pointer_width = $clog2(max_vc_number),
  localparam int occ_width        = $clog2(memory_bank_depth + 1),
  localparam int cred_width       = $clog2(credit_count + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         write_notify_i,
  input  logic [vc_pointer_width-1:0]  vc_written_into_i,
  output logic                         read_enable_o,
  output logic [vc_pointer_width-1:0]  vc_read_from_o,
  input  logic [memory_bank_width-1:0] bank_flit_i,
  output logic                         flit_valid_o,
  output logic [memory_bank_width-1:0] flit_out_o,
  output logic [vc_pointer_width-1:0]  flit_vc_o,
  input  logic                         credit_return_i,
  input  logic [vc_pointer_width-1:0]  credit_vc_i,
  output logic                         drain_error_o
);

  localparam logic [occ_width-1:0]  occ_full  = occ_width'(memory_bank_depth);
  localparam logic [cred_width-1:0] cred_full = cred_width'(credit_count);
  localparam logic [vc_pointer_width-1:0] rr_reset = vc_pointer_width'(max_vc_number - 1);

  logic [occ_width-1:0]  occ_q  [max_vc_number];
  logic [occ_width-1:0]  occ_d  [max_vc_number];
  logic [cred_width-1:0] cred_q [max_vc_number];
  logic [cred_width-1:0] cred_d [max_vc_number];

  logic [vc_pointer_width-1:0] rr_ptr_q, rr_ptr_d;
  logic                        drain_error_q, drain_error_d;

  logic                         rd_pend_q;
  logic [vc_pointer_width-1:0]  rd_vc_q;
  logic                         flit_valid_q;
  logic [memory_bank_width-1:0] flit_out_q;
  logic [vc_pointer_width-1:0]  flit_vc_q;

  logic [max_vc_number-1:0]    eligible;
  logic [max_vc_number-1:0]    wr_hit;
  logic [max_vc_number-1:0]    rd_hit;
  logic [max_vc_number-1:0]    cr_hit;
  logic                        grant_valid;
  logic [vc_pointer_width-1:0] grant_vc;

  always_comb begin
    eligible = '0;
    wr_hit   = '0;
    rd_hit   = '0;
    cr_hit   = '0;
    for (int v = 0; v < max_vc_number; v++) begin
      eligible[v] = (occ_q[v] != '0) && (cred_q[v] != '0);
      wr_hit[v]   = write_notify_i  && (vc_written_into_i == vc_pointer_width'(v));
      cr_hit[v]   = credit_return_i && (credit_vc_i == vc_pointer_width'(v));
      rd_hit[v]   = grant_valid && (grant_vc == vc_pointer_width'(v));
    end
  end

  // Search starts one past the last grant and wraps, so the last winner goes last.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_vc    = '0;
    for (int i = 1; i <= max_vc_number; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= max_vc_number) idx = idx - max_vc_number;
      if (!grant_valid && eligible[idx]) begin
        grant_valid = 1'b1;
        grant_vc    = vc_pointer_width'(idx);
      end
    end
  end

  // Overflowing events are flagged and dropped; coincident inc/dec cancel out.
  always_comb begin
    drain_error_d = drain_error_q;
    rr_ptr_d      = grant_valid ? grant_vc : rr_ptr_q;
    for (int v = 0; v < max_vc_number; v++) begin
      occ_d[v]  = occ_q[v];
      cred_d[v] = cred_q[v];

      if (wr_hit[v] && (occ_q[v] == occ_full)) drain_error_d = 1'b1;
      if (wr_hit[v] && !rd_hit[v] && (occ_q[v] != occ_full)) begin
        occ_d[v] = occ_q[v] + occ_width'(1);
      end else if (rd_hit[v] && !wr_hit[v]) begin
        occ_d[v] = occ_q[v] - occ_width'(1);
      end

      if (cr_hit[v] && (cred_q[v] == cred_full)) drain_error_d = 1'b1;
      if (cr_hit[v] && !rd_hit[v] && (cred_q[v] != cred_full)) begin
        cred_d[v] = cred_q[v] + cred_width'(1);
      end else if (rd_hit[v] && !cr_hit[v]) begin
        cred_d[v] = cred_q[v] - cred_width'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int v = 0; v < max_vc_number; v++) begin
        occ_q[v]  <= '0;
        cred_q[v] <= cred_full;
      end
      rr_ptr_q      <= rr_reset;
      drain_error_q <= 1'b0;
    end else begin
      for (int v = 0; v < max_vc_number; v++) begin
        occ_q[v]  <= occ_d[v];
        cred_q[v] <= cred_d[v];
      end
      rr_ptr_q      <= rr_ptr_d;
      drain_error_q <= drain_error_d;
    end
  end

  // Bank data arrives the cycle after the request; register it with its VC tag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_pend_q    <= 1'b0;
      rd_vc_q      <= '0;
      flit_valid_q <= 1'b0;
      flit_out_q   <= '0;
      flit_vc_q    <= '0;
    end else begin
      rd_pend_q    <= grant_valid;
      rd_vc_q      <= grant_vc;
      flit_valid_q <= rd_pend_q;
      if (rd_pend_q) begin
        flit_out_q <= bank_flit_i;
        flit_vc_q  <= rd_vc_q;
      end
    end
  end

  assign read_enable_o  = grant_valid;
  assign vc_read_from_o = grant_vc;
  assign flit_valid_o   = flit_valid_q;
  assign flit_out_o     = flit_out_q;
  assign flit_vc_o      = flit_vc_q;
  assign drain_error_o  = drain_error_q;

endmodule

// File: tb/tb_memory_bank_drain.sv
// Directed bench for memory_bank_drain: a behavioural bank returns queued flits
// and a scoreboard checks every output flit's VC tag and data in order.
module tb_memory_bank_drain;

  logic        clk_i;
  logic        rst_ni;
  logic        write_notify_i;
  logic [1:0]  vc_written_into_i;
  logic        read_enable_o;
  logic [1:0]  vc_read_from_o;
  logic [63:0] bank_flit_i = '0;
  logic        flit_valid_o;
  logic [63:0] flit_out_o;
  logic [1:0]  flit_vc_o;
  logic        credit_return_i;
  logic [1:0]  credit_vc_i;
  logic        drain_error_o;

  memory_bank_drain dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .write_notify_i    (write_notify_i),
    .vc_written_into_i (vc_written_into_i),
    .read_enable_o     (read_enable_o),
    .vc_read_from_o    (vc_read_from_o),
    .bank_flit_i       (bank_flit_i),
    .flit_valid_o      (flit_valid_o),
    .flit_out_o        (flit_out_o),
    .flit_vc_o         (flit_vc_o),
    .credit_return_i   (credit_return_i),
    .credit_vc_i       (credit_vc_i),
    .drain_error_o     (drain_error_o)
  );

  typedef struct {
    logic [1:0]  vc;
    logic [63:0] data;
  } exp_t;

  int          n_cmp  = 0;
  int          n_fail = 0;
  exp_t        exp_q [$];
  logic [63:0] bank_q [4][$];
  int          rd_cnt [4];
  logic [63:0] pend_data;
  bit          pend_valid = 0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_flit(input logic [1:0] vc, input logic [63:0] d);
    exp_t e;
    e.vc   = vc;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  // Drive one cycle of inputs from a negedge; returns at the following negedge.
  task automatic drive(input bit wn, input logic [1:0] wvc, input logic [63:0] wd,
                       input bit cr, input logic [1:0] cvc);
    write_notify_i    = wn;
    vc_written_into_i = wvc;
    credit_return_i   = cr;
    credit_vc_i       = cvc;
    if (wn) bank_q[wvc].push_back(wd);
    @(negedge clk_i);
    write_notify_i  = 1'b0;
    credit_return_i = 1'b0;
  endtask

  // Behavioural bank: a request seen in cycle T is answered during cycle T+1.
  always @(negedge clk_i) begin
    pend_valid = 0;
    if (rst_ni && read_enable_o) begin
      chk("bank_read_nonempty", 64'(bank_q[vc_read_from_o].size() != 0), 1);
      if (bank_q[vc_read_from_o].size() != 0) begin
        pend_data  = bank_q[vc_read_from_o].pop_front();
        pend_valid = 1;
        rd_cnt[vc_read_from_o]++;
      end
    end
  end

  always @(posedge clk_i) begin
    #1;
    bank_flit_i = pend_valid ? pend_data : 64'h0;
  end

  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni && flit_valid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_flit", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("flit_vc", flit_vc_o, e.vc);
        chk("flit_data", flit_out_o, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    logic [63:0] d;
    logic [1:0] rr_order [6];
    rr_order = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
    for (int v = 0; v < 4; v++) rd_cnt[v] = 0;

    rst_ni            = 1'b0;
    write_notify_i    = 1'b0;
    vc_written_into_i = '0;
    credit_return_i   = 1'b0;
    credit_vc_i       = '0;

    // Reset and idle
    #1;
    chk("rst_read_enable", read_enable_o, 0);
    chk("rst_vc_read_from", vc_read_from_o, 0);
    chk("rst_flit_valid", flit_valid_o, 0);
    chk("rst_flit_out", flit_out_o, 0);
    chk("rst_drain_error", drain_error_o, 0);
    repeat (3) tick();
    rst_ni = 1'b1;
    repeat (10) tick();
    chk("idle_read_enable", read_enable_o, 0);
    chk("idle_flit_valid", flit_valid_o, 0);
    chk("idle_drain_error", drain_error_o, 0);

    // Single write: read_enable at T+1, flit_valid at T+3
    expect_flit(2'd2, 64'hA5);
    drive(1, 2'd2, 64'hA5, 0, 2'd0);
    chk("lat_read_enable", read_enable_o, 1);
    chk("lat_vc_read_from", vc_read_from_o, 2);
    tick();
    chk("lat_read_enable_t2", read_enable_o, 0);
    chk("lat_flit_valid_t2", flit_valid_o, 0);
    tick();
    chk("lat_flit_valid_t3", flit_valid_o, 1);
    chk("lat_flit_vc_t3", flit_vc_o, 2);
    chk("lat_flit_out_t3", flit_out_o, 64'hA5);
    repeat (3) tick();

    // Credit exhaustion on VC0, then one returned credit buys one read
    base = rd_cnt[0];
    for (int i = 0; i < 8; i++) begin
      d = 64'h0D00 + 64'(i);
      if (i < 4) expect_flit(2'd0, d);
      drive(1, 2'd0, d, 0, 2'd0);
    end
    repeat (4) tick();
    chk("vc0_reads_4_credits", 64'(rd_cnt[0] - base), 4);
    chk("vc0_blocked_read_enable", read_enable_o, 0);
    expect_flit(2'd0, 64'h0D04);
    drive(0, 2'd0, 64'h0, 1, 2'd0);
    chk("credit_ret_read_enable", read_enable_o, 1);
    chk("credit_ret_vc", vc_read_from_o, 0);
    tick();
    chk("credit_ret_single_read", read_enable_o, 0);

    // Move the rr pointer to VC2, then contend VC0 (credit-blocked) against VC1
    expect_flit(2'd2, 64'h0E00);
    drive(1, 2'd2, 64'h0E00, 0, 2'd0);
    repeat (4) tick();
    expect_flit(2'd0, 64'h0D05);
    expect_flit(2'd1, 64'h0F00);
    expect_flit(2'd0, 64'h0D06);
    expect_flit(2'd1, 64'h0F01);
    expect_flit(2'd0, 64'h0D07);
    expect_flit(2'd1, 64'h0F02);
    for (int j = 0; j < 9; j++) begin
      chk("rr_read_enable", read_enable_o, 64'((j >= 1) && (j <= 6)));
      if ((j >= 1) && (j <= 6)) chk("rr_vc_order", vc_read_from_o, rr_order[j-1]);
      chk("rr_no_bubble_flit_valid", flit_valid_o, 64'(j >= 3));
      if (j < 3) drive(1, 2'd1, 64'h0F00 + 64'(j), 1, 2'd0);
      else tick();
    end

    // Write and read on VC1 in the same cycle keep occupancy at 1
    repeat (3) drive(0, 2'd0, 64'h0, 1, 2'd1);
    expect_flit(2'd1, 64'h1100);
    expect_flit(2'd1, 64'h1101);
    drive(1, 2'd1, 64'h1100, 0, 2'd0);
    chk("same_cycle_rd1", read_enable_o, 1);
    chk("same_cycle_vc1", vc_read_from_o, 1);
    drive(1, 2'd1, 64'h1101, 0, 2'd0);
    chk("same_cycle_rd2", read_enable_o, 1);
    chk("same_cycle_vc2", vc_read_from_o, 1);
    tick();
    chk("same_cycle_drained", read_enable_o, 0);
    chk("no_error_yet", drain_error_o, 0);

    // Occupancy overflow on credit-starved VC0
    for (int i = 0; i < 32; i++) drive(1, 2'd0, 64'h4800 + 64'(i), 0, 2'd0);
    chk("occ_full_no_error", drain_error_o, 0);
    chk("occ_full_no_read", read_enable_o, 0);
    drive(1, 2'd0, 64'h4820, 0, 2'd0);
    chk("occ_overflow_error", drain_error_o, 1);
    repeat (3) tick();
    chk("occ_overflow_sticky", drain_error_o, 1);

    // Reset in the middle of a VC0 burst
    expect_flit(2'd0, 64'h4800);
    expect_flit(2'd0, 64'h4801);
    repeat (4) drive(0, 2'd0, 64'h0, 1, 2'd0);
    chk("burst_flit_valid", flit_valid_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("midrst_flit_valid", flit_valid_o, 0);
    chk("midrst_read_enable", read_enable_o, 0);
    chk("midrst_flit_out", flit_out_o, 0);
    chk("midrst_flit_vc", flit_vc_o, 0);
    chk("midrst_drain_error", drain_error_o, 0);
    chk("midrst_scoreboard_empty", 64'(exp_q.size()), 0);
    exp_q.delete();
    for (int v = 0; v < 4; v++) begin
      bank_q[v].delete();
      rd_cnt[v] = 0;
    end
    repeat (2) tick();
    rst_ni = 1'b1;

    // Every VC back at four credits; VC0 served first
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 5; i++) begin
        d = 64'h6000 + 64'(v * 16 + i);
        if (i < 4) expect_flit(2'(v), d);
        drive(1, 2'(v), d, 0, 2'd0);
        if (v == 0 && i == 0) begin
          chk("post_rst_first_rd", read_enable_o, 1);
          chk("post_rst_first_vc", vc_read_from_o, 0);
        end
      end
    end
    repeat (4) tick();
    for (int v = 0; v < 4; v++) chk("post_rst_cred4_reads", 64'(rd_cnt[v]), 4);
    chk("post_rst_blocked", read_enable_o, 0);

    // Credit overflow on VC3 and credit saturation
    expect_flit(2'd3, 64'h6034);
    drive(0, 2'd0, 64'h0, 1, 2'd3);
    chk("vc3_refill_rd", read_enable_o, 1);
    chk("vc3_refill_vc", vc_read_from_o, 3);
    repeat (3) tick();
    repeat (4) drive(0, 2'd0, 64'h0, 1, 2'd3);
    chk("cred_full_no_error", drain_error_o, 0);
    drive(0, 2'd0, 64'h0, 1, 2'd3);
    chk("cred_overflow_error", drain_error_o, 1);
    repeat (3) tick();
    chk("cred_overflow_sticky", drain_error_o, 1);
    base = rd_cnt[3];
    for (int i = 0; i < 5; i++) begin
      d = 64'h7300 + 64'(i);
      if (i < 4) expect_flit(2'd3, d);
      drive(1, 2'd3, d, 0, 2'd0);
    end
    repeat (4) tick();
    chk("cred_saturated_reads", 64'(rd_cnt[3] - base), 4);
    chk("cred_saturated_blocked", read_enable_o, 0);

    repeat (4) tick();
    chk("final_scoreboard_empty", 64'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
